mmio_controller: RTL and testbench
==================================

# mmio_controller

Memory-mapped I/O controller sitting directly downstream of the processor's data-memory port: it decodes the 0xF000_00xx I/O window, owns the LEDR/LEDG/HEX output registers, and synchronises and debounces the board KEY and SW inputs. The data-memory path forwards every access; this block claims I/O addresses and returns read data combinationally from registered state. It also provides sticky key-press capture, so software polling loops cannot miss short presses.

## Interface
Parameters:
- DBITS, 32, data/address width
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before a debounced input changes (set to 4 in simulation)

Ports:
- clk  input  1  system clock (PLL c0)
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- addr  input  DBITS  byte address from ALU result
- wrtEn  input  1  store strobe
- dIn  input  DBITS  store data
- dOut  output  DBITS  load data; 0 for unmapped or non-I/O addresses
- isIo  output  1  addr[31:28] == 4'hF; data-memory read mux selects dOut when high
- key_raw  input  4  board KEY, active-low
- sw_raw  input  10  board SW
- ledr  output  10  LEDR drive
- ledg  output  8  LEDG drive
- hex  output  16  four hex nibbles, [15:12] = HEX3

## Operation
- Register map (word offsets, addr[1:0] ignored):
  - 0xF0000000 HEX: R/W, bits [15:0]
  - 0xF0000004 LEDR: R/W, bits [9:0]
  - 0xF0000008 LEDG: R/W, bits [7:0]
  - 0xF0000010 KEY: RO, debounced state, 1 = pressed, bits [3:0]
  - 0xF0000014 SW: RO, debounced state, bits [9:0]
  - 0xF0000018 KEYEDGE: sticky press flags [3:0]; write-1-to-clear
- Unused high bits read 0; writes to RO or unmapped I/O addresses are ignored. Unmapped I/O addresses read 0.
- Writes with isIo low are ignored.
- Input path, per bit: 2-flop synchroniser, then debouncer.
  - The debouncer holds a stable value and a counter.
  - The counter increments while the synchronised value differs from the stable value. It clears whenever the values match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the values still differ, the stable value toggles and the counter clears.
- KEY is inverted after synchronisation, so the internal 1 means pressed.
- KEYEDGE bit i is set on the cycle debounced KEY[i] goes 0→1.
  - A W1C write on the same cycle as a set: set wins (bit ends at 1).
- Reset values:
  - ledr, ledg, hex, KEYEDGE, all counters: 0
  - synchroniser flops: key = 1 (released), sw = 0
  - debounced KEY = 0, debounced SW = 0
  - dOut reflects these values combinationally.

## Timing
- Writes take effect on the rising clk edge with wrtEn high. New ledr/ledg/hex values appear the following cycle.
- Reads are combinational from addr. No wait states, so single-cycle load semantics are preserved.
- Raw input to debounced state: exactly 2 + DEBOUNCE_CYCLES rising edges of stable input. KEYEDGE sets on the same edge.
- A glitch shorter than DEBOUNCE_CYCLES post-sync cycles produces no change.
- Reset asserted mid-debounce discards the count; the input must be stable for the full window after release.
- SW at reset release: a switch already on yields debounced 1 after 2 + DEBOUNCE_CYCLES cycles.

## Structure
- Shared package: the I/O address constants (ADDR_HEX, ADDR_LEDR, ADDR_LEDG, ADDR_KEY, ADDR_SW, ADDR_KEYEDGE) and the I/O-window nibble 4'hF. These are shared with the processor top and the data-memory block.
- One sub-module: input_debouncer, parameterised by width, DEBOUNCE_CYCLES and synchroniser reset value. It contains the synchroniser and per-bit counters and is instantiated once for KEY (4 bits) and once for SW (10 bits).
- Address decode, output registers, KEYEDGE logic and the read mux live in mmio_controller.

## Test plan
All tests use DEBOUNCE_CYCLES = 4.
- Reset: hold reset=0 for 3 cycles, then release → ledr=0, ledg=0, hex=0, and reads of 0xF0000010/14/18 return 0.
- Store: write 0x1234 to 0xF0000000 and 0x3FF to 0xF0000004 → next cycle hex=0x1234, ledr=0x3FF. Reads return the same values.
- Non-I/O store: write 0xFF to 0x00000008 → ledg unchanged, isIo=0, dOut=0.
- Debounce: drive key_raw[2]=0 steadily → KEY read = 0x4 exactly 6 edges later and KEYEDGE=0x4. A 3-cycle low pulse on key_raw[1] → no change.
- KEYEDGE clear: write 0x4 to 0xF0000018 → reads 0. Then a W1C write on the same cycle as a new key[0] press edge → KEYEDGE bit 0 = 1.
- Reset mid-debounce: sw_raw[5]=1 for 4 cycles, then reset for 1 cycle → SW reads 0 until 6 stable cycles after release, then 0x20.

Source files
------------

// File: rtl/mmio_controller_pkg.sv
// Shared I/O window constants for the processor top, data memory and MMIO block.
package mmio_controller_pkg;

   localparam logic [3:0]  IO_NIBBLE    = 4'hF;

   localparam logic [31:0] ADDR_HEX     = 32'hF000_0000;
   localparam logic [31:0] ADDR_LEDR    = 32'hF000_0004;
   localparam logic [31:0] ADDR_LEDG    = 32'hF000_0008;
   localparam logic [31:0] ADDR_KEY     = 32'hF000_0010;
   localparam logic [31:0] ADDR_SW      = 32'hF000_0014;
   localparam logic [31:0] ADDR_KEYEDGE = 32'hF000_0018;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a per-bit stable-value debouncer.
// rise flags the edge on which a stable bit is about to go 0 -> 1.
module input_debouncer #(
   parameter int   WIDTH           = 4,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic SYNC_INIT       = 1'b0,
   parameter logic INVERT          = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] stable,
   output logic [WIDTH-1:0] rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] sample;
   logic [WIDTH-1:0] done;
   logic [CW-1:0]    cnt [WIDTH];

   // Inversion happens after the synchroniser so the flops keep the raw reset level.
   assign sample = sync2 ^ {WIDTH{INVERT}};
   assign rise   = done & ~stable;

   always_comb begin
      done = '0;
      for (int i = 0; i < WIDTH; i++)
         done[i] = (sample[i] != stable[i]) && (cnt[i] == TERM);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1  <= {WIDTH{SYNC_INIT}};
         sync2  <= {WIDTH{SYNC_INIT}};
         stable <= '0;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < WIDTH; i++) begin
            if (sample[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (done[i]) begin
               stable[i] <= ~stable[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mmio_controller.sv
// I/O window decode, LED/HEX output registers, sticky key-press capture and
// combinational read-back for the processor data-memory port.
module mmio_controller
   import mmio_controller_pkg::*;
#(
   parameter int DBITS           = 32,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] addr,
   input  logic             wrtEn,
   input  logic [DBITS-1:0] dIn,
   output logic [DBITS-1:0] dOut,
   output logic             isIo,
   input  logic [3:0]       key_raw,
   input  logic [9:0]       sw_raw,
   output logic [9:0]       ledr,
   output logic [7:0]       ledg,
   output logic [15:0]      hex
);

   logic [DBITS-1:0] addr_word;
   logic [3:0]       key;
   logic [3:0]       key_rise;
   logic [9:0]       sw;
   logic [9:0]       sw_rise_unused;
   logic [3:0]       keyedge;
   logic             io_wr;
   logic             unused_bits;

   assign addr_word   = {addr[DBITS-1:2], 2'b00};
   assign isIo        = (addr[DBITS-1 -: 4] == IO_NIBBLE);
   assign io_wr       = wrtEn && isIo;
   assign unused_bits = ^{dIn[DBITS-1:16], addr[1:0], sw_rise_unused};

   input_debouncer #(
      .WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_INIT(1'b1), .INVERT(1'b1)
   ) u_key_db (
      .clk(clk), .reset(reset), .raw(key_raw), .stable(key), .rise(key_rise)
   );

   input_debouncer #(
      .WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_INIT(1'b0), .INVERT(1'b0)
   ) u_sw_db (
      .clk(clk), .reset(reset), .raw(sw_raw), .stable(sw), .rise(sw_rise_unused)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         hex     <= '0;
         ledr    <= '0;
         ledg    <= '0;
         keyedge <= '0;
      end else begin
         if (io_wr && addr_word == DBITS'(ADDR_HEX))  hex  <= dIn[15:0];
         if (io_wr && addr_word == DBITS'(ADDR_LEDR)) ledr <= dIn[9:0];
         if (io_wr && addr_word == DBITS'(ADDR_LEDG)) ledg <= dIn[7:0];
         // A press landing on the same edge as a clear must survive.
         if (io_wr && addr_word == DBITS'(ADDR_KEYEDGE))
            keyedge <= (keyedge & ~dIn[3:0]) | key_rise;
         else
            keyedge <= keyedge | key_rise;
      end
   end

   always_comb begin
      dOut = '0;
      if (isIo) begin
         case (addr_word)
            DBITS'(ADDR_HEX):     dOut = DBITS'(hex);
            DBITS'(ADDR_LEDR):    dOut = DBITS'(ledr);
            DBITS'(ADDR_LEDG):    dOut = DBITS'(ledg);
            DBITS'(ADDR_KEY):     dOut = DBITS'(key);
            DBITS'(ADDR_SW):      dOut = DBITS'(sw);
            DBITS'(ADDR_KEYEDGE): dOut = DBITS'(keyedge);
            default:              dOut = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_controller.sv
// Directed bench for mmio_controller with a 4-cycle debounce window.
module tb_mmio_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        wrtEn;
   logic [31:0] dIn;
   logic [31:0] dOut;
   logic        isIo;
   logic [3:0]  key_raw;
   logic [9:0]  sw_raw;
   logic [9:0]  ledr;
   logic [7:0]  ledg;
   logic [15:0] hex;

   int checks   = 0;
   int failures = 0;

   mmio_controller #(.DBITS(32), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wrtEn(wrtEn), .dIn(dIn),
      .dOut(dOut), .isIo(isIo), .key_raw(key_raw), .sw_raw(sw_raw),
      .ledr(ledr), .ledg(ledg), .hex(hex)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] a;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_io;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(name, dOut, exp);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      dIn   = d;
      wrtEn = 1'b1;
      @(posedge clk);
      #1;
      wrtEn = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'hF000_0000, 32'h0000_1234, 32'h0000_1234, 1'b1};
      vecs[1]  = '{1'b1, 32'hF000_0004, 32'h0000_03FF, 32'h0000_03FF, 1'b1};
      vecs[2]  = '{1'b1, 32'hF000_0008, 32'hFFFF_FFA5, 32'h0000_00A5, 1'b1};
      vecs[3]  = '{1'b1, 32'h0000_0008, 32'h0000_00FF, 32'h0000_0000, 1'b0};
      vecs[4]  = '{1'b1, 32'hF000_0010, 32'h0000_000F, 32'h0000_0000, 1'b1};
      vecs[5]  = '{1'b1, 32'hF000_0014, 32'h0000_03FF, 32'h0000_0000, 1'b1};
      vecs[6]  = '{1'b1, 32'hF000_000C, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b0, 32'hF000_0002, 32'h0000_0000, 32'h0000_1234, 1'b1};
      vecs[8]  = '{1'b1, 32'hF000_0004, 32'hFFFF_FC01, 32'h0000_0001, 1'b1};
      vecs[9]  = '{1'b1, 32'hF000_0006, 32'h0000_02AA, 32'h0000_02AA, 1'b1};
      vecs[10] = '{1'b0, 32'h8000_0004, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[11] = '{1'b1, 32'hF000_0000, 32'hABCD_5678, 32'h0000_5678, 1'b1};

      reset   = 1'b0;
      addr    = '0;
      wrtEn   = 1'b0;
      dIn     = '0;
      key_raw = 4'hF;
      sw_raw  = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_ledr", 32'(ledr), 32'h0);
      check("rst_ledg", 32'(ledg), 32'h0);
      check("rst_hex",  32'(hex),  32'h0);
      read_check("rst_key",     32'hF000_0010, 32'h0);
      read_check("rst_sw",      32'hF000_0014, 32'h0);
      read_check("rst_keyedge", 32'hF000_0018, 32'h0);

      // Register map vectors: write (or not), then read back the same address.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         addr  = vecs[i].a;
         dIn   = vecs[i].wdata;
         wrtEn = vecs[i].wr;
         @(posedge clk);
         #1;
         wrtEn = 1'b0;
         #1;
         check($sformatf("vec%0d_dout", i), dOut, vecs[i].exp_rd);
         check($sformatf("vec%0d_isio", i), 32'(isIo), 32'(vecs[i].exp_io));
      end
      check("out_hex",  32'(hex),  32'h5678);
      check("out_ledr", 32'(ledr), 32'h2AA);
      check("out_ledg", 32'(ledg), 32'hA5);

      // KEY[2] press: debounced after exactly 6 edges.
      @(negedge clk);
      key_raw[2] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      read_check("key2_edge5", 32'hF000_0010, 32'h0);
      read_check("keyedge_edge5", 32'hF000_0018, 32'h0);
      @(posedge clk);
      #1;
      read_check("key2_edge6", 32'hF000_0010, 32'h4);
      read_check("keyedge_edge6", 32'hF000_0018, 32'h4);

      // 3-cycle glitch on KEY[1] must not register.
      @(negedge clk);
      key_raw[1] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      key_raw[1] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      read_check("glitch_key", 32'hF000_0010, 32'h4);
      read_check("glitch_keyedge", 32'hF000_0018, 32'h4);

      // W1C clear, then clear colliding with a fresh KEY[0] press.
      bus_write(32'hF000_0018, 32'h4);
      read_check("w1c_clear", 32'hF000_0018, 32'h0);
      @(negedge clk);
      key_raw[0] = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      addr  = 32'hF000_0018;
      dIn   = 32'h1;
      wrtEn = 1'b1;
      @(posedge clk);
      #1;
      wrtEn = 1'b0;
      read_check("w1c_vs_set", 32'hF000_0018, 32'h1);
      read_check("key_both", 32'hF000_0010, 32'h5);
      bus_write(32'hF000_0018, 32'h1);
      read_check("w1c_clear2", 32'hF000_0018, 32'h0);

      // Reset mid-debounce discards the SW[5] count.
      @(negedge clk);
      sw_raw[5] = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      read_check("rst_mid_sw", 32'hF000_0014, 32'h0);
      read_check("rst_mid_key", 32'hF000_0010, 32'h0);
      check("rst_mid_ledr", 32'(ledr), 32'h0);
      repeat (5) @(posedge clk);
      #1;
      read_check("sw_edge5", 32'hF000_0014, 32'h0);
      @(posedge clk);
      #1;
      read_check("sw_edge6", 32'hF000_0014, 32'h20);
      read_check("key_after_rst", 32'hF000_0010, 32'h5);
      read_check("keyedge_after_rst", 32'hF000_0018, 32'h5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
